// File: rtl/aes_256_inv_cipher_iter_if.sv
// Handshake and key-store bundle for the iterative AES-256 inverse cipher core.
// The slave modport is the core side; the master modport is the producer/consumer/key-store side.
interface aes_256_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_text;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_text;
    logic         busy;

    modport slave (
        input  in_valid,
        input  cipher_text,
        input  round_key,
        input  out_ready,
        output in_ready,
        output rk_idx,
        output out_valid,
        output plain_text,
        output busy
    );

    modport master (
        output in_valid,
        output cipher_text,
        output round_key,
        output out_ready,
        input  in_ready,
        input  rk_idx,
        input  out_valid,
        input  plain_text,
        input  busy
    );
endinterface

// File: rtl/aes_256_inv_cipher_iter.sv
// Iterative AES-256 inverse cipher: one inverse round per clock, 14 rounds.
// Round keys come from an external key store addressed by rk_idx.
module aes_256_inv_cipher_iter (
    input  logic                            clk,
    input  logic                            rst_n,
    aes_256_inv_cipher_iter_if.slave        bus_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e         fsmState_q, fsmState_d;
    logic [3:0]   roundCnt_q, roundCnt_d;
    logic [127:0] stateBlk_q, stateBlk_d;
    logic [127:0] plainText_q, plainText_d;
    logic         outValid_q, outValid_d;

    logic [127:0] shifted;
    logic [127:0] subBytes;
    logic [127:0] keyed;
    logic [127:0] mixed;
    logic [127:0] roundOut;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 via a fixed addition chain; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gfMul(x, x);
        x3   = gfMul(x2, x);
        x6   = gfMul(x3, x3);
        x7   = gfMul(x6, x);
        x14  = gfMul(x7, x7);
        x15  = gfMul(x14, x);
        x30  = gfMul(x15, x15);
        x31  = gfMul(x30, x);
        x62  = gfMul(x31, x31);
        x63  = gfMul(x62, x);
        x126 = gfMul(x63, x63);
        x127 = gfMul(x126, x);
        return gfMul(x127, x127);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < k; i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform first, then invert in GF(2^8).
    function automatic logic [7:0] invSbox(input logic [7:0] b);
        logic [7:0] a;
        a = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return gfInv(a);
    endfunction

    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] invMixCol(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign shifted = invShiftRows(stateBlk_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign subBytes[127-8*i -: 8] = invSbox(shifted[127-8*i -: 8]);
    end

    assign keyed = subBytes ^ bus_if.round_key;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127-32*c -: 32] = invMixCol(keyed[127-32*c -: 32]);
    end

    // The last round (counter at zero) skips InvMixColumns.
    assign roundOut = (roundCnt_q == 4'd0) ? keyed : mixed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsmState_q  <= IDLE;
            roundCnt_q  <= 4'd0;
            stateBlk_q  <= '0;
            plainText_q <= '0;
            outValid_q  <= 1'b0;
        end else begin
            fsmState_q  <= fsmState_d;
            roundCnt_q  <= roundCnt_d;
            stateBlk_q  <= stateBlk_d;
            plainText_q <= plainText_d;
            outValid_q  <= outValid_d;
        end
    end

    always_comb begin
        fsmState_d  = fsmState_q;
        roundCnt_d  = roundCnt_q;
        stateBlk_d  = stateBlk_q;
        plainText_d = plainText_q;
        outValid_d  = outValid_q;
        unique case (fsmState_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    stateBlk_d = bus_if.cipher_text ^ bus_if.round_key;
                    roundCnt_d = 4'd13;
                    fsmState_d = ROUND;
                end
            end
            ROUND: begin
                stateBlk_d = roundOut;
                if (roundCnt_q == 4'd0) begin
                    plainText_d = roundOut;
                    outValid_d  = 1'b1;
                    fsmState_d  = DONE;
                end else begin
                    roundCnt_d = roundCnt_q - 4'd1;
                end
            end
            DONE: begin
                if (bus_if.out_ready) begin
                    outValid_d = 1'b0;
                    fsmState_d = IDLE;
                end
            end
            default: begin
                fsmState_d = IDLE;
            end
        endcase
    end

    assign bus_if.in_ready   = (fsmState_q == IDLE);
    assign bus_if.busy       = (fsmState_q != IDLE);
    assign bus_if.rk_idx     = (fsmState_q == ROUND) ? roundCnt_q : 4'd14;
    assign bus_if.out_valid  = outValid_q;
    assign bus_if.plain_text = plainText_q;

endmodule

// File: tb/tb_aes_256_inv_cipher_iter.sv
// Self-checking bench for aes_256_inv_cipher_iter: directed vector table, multi-cycle corner
// sequences, and a random encrypt/decrypt round-trip using a forward-cipher reference model.
module tb_aes_256_inv_cipher_iter;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_256_inv_cipher_iter_if bus ();

    aes_256_inv_cipher_iter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    logic [127:0] rkTable [16];
    assign bus.round_key = rkTable[bus.rk_idx];

    logic [7:0]   sboxT [256];
    int           nApplied;
    int           nMiscompare;
    int           rkSeen [16];
    int           lastLatency;
    logic [127:0] lastResult;

    typedef struct {
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int k);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
    endfunction

    function automatic logic [127:0] keyRound(input logic [255:0] key, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xt(rcon);
            end else if (i % 8 == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Forward cipher reference: the DUT is checked by decrypting what this produces.
    function automatic logic [127:0] encrypt(input logic [255:0] key, input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ keyRound(key, 0);
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sboxT[s[127-8*i -: 8]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            s = t;
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ keyRound(key, r);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        nApplied++;
        if (actual != expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadKey(input logic [255:0] key);
        for (int r = 0; r < 15; r++) rkTable[r] = keyRound(key, r);
        rkTable[15] = '0;
    endtask

    // Runs one block end to end; keepValid leaves in_valid high with altCt after the accept edge.
    task automatic applyStimulus(input logic [255:0] key, input logic [127:0] ct, input int preGap,
                                 input int holdCycles, input bit keepValid, input logic [127:0] altCt);
        int n;
        for (int i = 0; i < 16; i++) rkSeen[i] = -1;
        lastResult  = 'x;
        lastLatency = -1;
        loadKey(key);
        repeat (preGap) tick();
        bus.cipher_text = ct;
        bus.in_valid    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 64) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checkBit("in_ready wait timeout", bus.in_ready, 1'b1);
            bus.in_valid = 1'b0;
            return;
        end
        rkSeen[0] = int'(bus.rk_idx);
        tick();
        if (keepValid) bus.cipher_text = altCt;
        else           bus.in_valid    = 1'b0;
        lastLatency = 0;
        while (!bus.out_valid && lastLatency < 40) begin
            if (lastLatency < 15) rkSeen[lastLatency+1] = int'(bus.rk_idx);
            checkBit("in_ready low in ROUND", bus.in_ready, 1'b0);
            checkBit("busy high in ROUND", bus.busy, 1'b1);
            tick();
            lastLatency++;
        end
        if (!bus.out_valid) begin
            checkBit("out_valid wait timeout", bus.out_valid, 1'b1);
            bus.in_valid = 1'b0;
            return;
        end
        rkSeen[15] = int'(bus.rk_idx);
        lastResult = bus.plain_text;
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkBit("out_valid held", bus.out_valid, 1'b1);
            checkOutput("plain_text held", bus.plain_text, lastResult);
            checkBit("in_ready low in DONE", bus.in_ready, 1'b0);
            checkBit("busy high in DONE", bus.busy, 1'b1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkBit("out_valid after handshake", bus.out_valid, 1'b0);
        checkBit("in_ready after handshake", bus.in_ready, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no summary, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t         vecs [4];
        logic [127:0] altPt;
        logic [127:0] altCt;
        logic [255:0] rKey;
        logic [127:0] rPt;
        logic [7:0]   inv;
        logic [7:0]   xb;
        bit           sawPulse;
        int           n;

        nApplied    = 0;
        nMiscompare = 0;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            sboxT[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end

        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.cipher_text = '0;
        loadKey('0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checkBit("reset in_ready", bus.in_ready, 1'b1);
        checkBit("reset busy", bus.busy, 1'b0);
        checkBit("reset out_valid", bus.out_valid, 1'b0);
        checkInt("reset rk_idx", int'(bus.rk_idx), 14);
        checkOutput("reset plain_text", bus.plain_text, 128'h0);

        vecs[0] = '{key: C3_KEY, ct: C3_CT, pt: C3_PT};
        vecs[1] = '{key: '0, ct: encrypt('0, '0), pt: '0};
        vecs[2] = '{key: '1, ct: encrypt('1, '1), pt: '1};
        vecs[3] = '{key: C3_KEY, ct: encrypt(C3_KEY, 128'h0), pt: 128'h0};

        for (int v = 0; v < 4; v++) begin
            bus.out_ready = 1'b0;
            applyStimulus(vecs[v].key, vecs[v].ct, 0, 0, 1'b0, '0);
            checkOutput("vector plain_text", lastResult, vecs[v].pt);
            checkInt("vector latency", lastLatency, 14);
            if (v == 0) begin
                for (int k = 0; k < 16; k++)
                    checkInt("C.3 rk_idx sequence", rkSeen[k], (k == 0 || k == 15) ? 14 : 14 - k);
            end
        end

        $display("[TB] backpressure sequence");
        applyStimulus(C3_KEY, C3_CT, 1, 5, 1'b0, '0);
        checkOutput("backpressure plain_text", lastResult, C3_PT);
        checkInt("backpressure latency", lastLatency, 14);

        $display("[TB] busy rejection sequence");
        altPt = 128'h0123456789abcdeffedcba9876543210;
        altCt = encrypt(C3_KEY, altPt);
        applyStimulus(C3_KEY, C3_CT, 0, 2, 1'b1, altCt);
        checkOutput("busy-reject first result", lastResult, C3_PT);
        applyStimulus(C3_KEY, altCt, 0, 0, 1'b0, '0);
        checkOutput("busy-reject second result", lastResult, altPt);
        checkInt("busy-reject second latency", lastLatency, 14);

        $display("[TB] mid-operation reset sequence");
        loadKey(C3_KEY);
        bus.cipher_text = C3_CT;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.rk_idx != 4'd7 && n < 40) begin
            tick();
            n++;
        end
        checkInt("reached rk_idx 7", int'(bus.rk_idx), 7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkBit("mid-reset out_valid", bus.out_valid, 1'b0);
        checkBit("mid-reset in_ready", bus.in_ready, 1'b1);
        checkBit("mid-reset busy", bus.busy, 1'b0);
        checkInt("mid-reset rk_idx", int'(bus.rk_idx), 14);
        checkOutput("mid-reset plain_text", bus.plain_text, 128'h0);
        sawPulse = 1'b0;
        repeat (20) begin
            tick();
            if (bus.out_valid) sawPulse = 1'b1;
        end
        checkBit("no out_valid after reset", sawPulse, 1'b0);
        applyStimulus(C3_KEY, C3_CT, 0, 0, 1'b0, '0);
        checkOutput("post-reset C.3", lastResult, C3_PT);

        $display("[TB] random round-trip");
        for (int b = 0; b < 1000; b++) begin
            rKey = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            rPt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(rKey, encrypt(rKey, rPt), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 1'b0, '0);
            checkOutput("random round-trip", lastResult, rPt);
            checkInt("random latency", lastLatency, 14);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
